// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths, NOP encoding,
// control-transfer opcodes and the redirect-source encoding.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W  = 19;
   localparam int unsigned CPU_INSTR_W = 19;

   localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 19'h0;

   localparam logic [4:0] OPC_CALL = 5'b01101;
   localparam logic [4:0] OPC_RET  = 5'b01110;

   typedef enum logic [1:0] {
      NONE,
      BRANCH,
      EXCEPTION
   } redirect_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the fetch queue.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, flush (wins over
// push/pop), full, empty, count (occupancy).
// Push on a full FIFO is accepted only together with a pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage array, not reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: issues sequential word fetches, buffers in-order
// responses with their PCs and presents one instruction per cycle to decode.
// Ports: clk, rst (sync, active-high); imem_req_* request channel;
// imem_rsp_* response channel; stall from decode; branch_taken/branch_target
// and exception/handler_address redirects; instr_valid/pc/instruction to IF/ID.
// Optional build macro FETCH_BYPASS_EN: a response arriving at an empty queue
// with nothing to drop is presented in the same cycle.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = CPU_ADDR_W,
   parameter int unsigned       INSTR_W  = CPU_INSTR_W,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               exception,
   input  logic [ADDR_W-1:0]  handler_address,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instruction
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0] rsp_pc, rsp_pc_nxt;
   logic [CNT_W-1:0]  inflight, inflight_nxt;
   logic [CNT_W-1:0]  drop_cnt, drop_cnt_nxt;
   logic              rst_q;

   redirect_e         redir_src;
   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic [SUM_W-1:0]  credit_used;
   logic              accept;
   logic              rsp_take;
   logic              bypass;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [ENT_W-1:0]  fifo_dout;

   // Redirect source selection; exception outranks branch
   always_comb begin
      redir_src = NONE;
      target    = branch_target;
      if (exception) begin
         redir_src = EXCEPTION;
         target    = handler_address;
      end else if (branch_taken) begin
         redir_src = BRANCH;
      end
   end

   assign redirect = (redir_src != NONE);

   // Issue credit, response accounting and next-state computation
   always_comb begin
      credit_used    = SUM_W'(fifo_count) + SUM_W'(inflight);
      // no issue while in reset, in the release cycle, or on a redirect
      imem_req_valid = !rst && !rst_q && !redirect && !fifo_full &&
                       (credit_used < SUM_W'(DEPTH));
      imem_req_addr  = fetch_pc;
      accept         = imem_req_valid && imem_req_ready;
      rsp_take       = imem_rsp_valid && !redirect && (drop_cnt == '0);
`ifdef FETCH_BYPASS_EN
      bypass         = rsp_take && fifo_empty;
`else
      bypass         = 1'b0;
`endif
      // a bypassed response that decode takes immediately is never stored
      fifo_push      = rsp_take && !(bypass && !stall);
      fifo_pop       = !fifo_empty && !stall && !redirect;

      inflight_nxt   = inflight + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

      drop_cnt_nxt   = drop_cnt;
      if (redirect) begin
         // everything still outstanding after this cycle is stale
         drop_cnt_nxt = inflight_nxt;
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
         drop_cnt_nxt = drop_cnt - CNT_W'(1);
      end

      fetch_pc_nxt = fetch_pc;
      rsp_pc_nxt   = rsp_pc;
      if (redirect) begin
         fetch_pc_nxt = target;
         rsp_pc_nxt   = target;
      end else begin
         if (accept)   fetch_pc_nxt = fetch_pc + ADDR_W'(1);
         if (rsp_take) rsp_pc_nxt   = rsp_pc + ADDR_W'(1);
      end
   end

   // Presented instruction: bypassed response, else queue head, else bubble
   always_comb begin
      instr_valid = 1'b0;
      pc          = '0;
      instruction = INSTR_W'(NOP_INSTR);
      if (bypass) begin
         instr_valid = 1'b1;
         pc          = rsp_pc;
         instruction = imem_rsp_data;
      end else if (!fifo_empty) begin
         instr_valid          = 1'b1;
         {pc, instruction}    = fifo_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         rst_q    <= 1'b1;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         rsp_pc   <= rsp_pc_nxt;
         inflight <= inflight_nxt;
         drop_cnt <= drop_cnt_nxt;
         rst_q    <= 1'b0;
      end
   end

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect),
      .din   ({rsp_pc, imem_rsp_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with variable
// latency, directed redirect table and hand-written reset/stall sequences.
module tb_fetch_queue;
   localparam int unsigned AW = 19;

`ifdef FETCH_BYPASS_EN
   localparam int FIRST_LAT = 2;
   localparam int FIRST_CNT = 11;
`else
   localparam int FIRST_LAT = 3;
   localparam int FIRST_CNT = 10;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          imem_req_valid;
   logic          imem_req_ready = 1'b0;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid = 1'b0;
   logic [AW-1:0] imem_rsp_data = '0;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          exception = 1'b0;
   logic [AW-1:0] handler_address = '0;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic [AW-1:0] instruction;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .exception       (exception),
      .handler_address (handler_address),
      .instr_valid     (instr_valid),
      .pc              (pc),
      .instruction     (instruction)
   );

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } mreq_t;

   typedef struct {
      logic          br;
      logic          ex;
      logic          twice;
      logic [AW-1:0] bt;
      logic [AW-1:0] ha;
      logic [AW-1:0] e0;
      logic [AW-1:0] e1;
      logic [AW-1:0] e2;
   } vec_t;

   mreq_t         mq[$];
   logic [AW-1:0] got[$];
   vec_t          vecs[6];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] exp_fetch;
   logic [AW-1:0] exp_pc;
   bit            redir_prev;
   bit            rand_ready;
   bit            rand_rsp;
   int            lat_extra_max;
   int            acc_total;
   int            cons_total;
   int            first_valid_cyc;
   int            release_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [AW-1:0] mem_data(input logic [AW-1:0] a);
      return a ^ 19'h2B5C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, model memory, check outputs, advance
   task automatic step(input bit stl, input bit br, input bit ex,
                       input logic [AW-1:0] bt, input logic [AW-1:0] ha);
      bit rsp_go;
      bit redir;
      bit acc;
      @(negedge clk);
      stall           = stl;
      branch_taken    = br;
      exception       = ex;
      branch_target   = bt;
      handler_address = ha;
      imem_req_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp_go = 1'b0;
      if (mq.size() > 0)
         if (mq[0].due <= cyc)
            rsp_go = rand_rsp ? ($urandom_range(0, 1) == 1) : 1'b1;
      imem_rsp_valid = rsp_go;
      if (rsp_go) imem_rsp_data = mem_data(mq[0].addr);
      else        imem_rsp_data = AW'($urandom);
      #1;
      redir = br || ex;
      acc   = imem_req_valid && imem_req_ready;
      if (redir)      check("no_req_on_redirect", 32'(imem_req_valid), 32'(0));
      if (redir_prev) check("bubble_after_redirect", 32'(instr_valid), 32'(0));
      if (instr_valid) begin
         check("pc", 32'(pc), 32'(exp_pc));
         check("instruction", 32'(instruction), 32'(mem_data(exp_pc)));
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end else begin
         check("bubble_nop", 32'(instruction), 32'(0));
      end
      if (acc) begin
         check("req_addr", 32'(imem_req_addr), 32'(exp_fetch));
         exp_fetch = exp_fetch + AW'(1);
         acc_total++;
      end
      if (rsp_go) void'(mq.pop_front());
      if (acc) mq.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(0, lat_extra_max))});
      if (instr_valid && !stl && !redir) begin
         got.push_back(pc);
         exp_pc = exp_pc + AW'(1);
         cons_total++;
      end
      if (redir) begin
         exp_pc    = ex ? ha : bt;
         exp_fetch = exp_pc;
      end
      redir_prev = redir;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      stall           = 1'b0;
      branch_taken    = 1'b0;
      exception       = 1'b0;
      imem_req_ready  = 1'b1;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = '0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'(0));
      check("rst_instr_valid", 32'(instr_valid), 32'(0));
      check("rst_pc", 32'(pc), 32'(0));
      check("rst_instruction", 32'(instruction), 32'(0));
      mq.delete();
      got.delete();
      exp_fetch       = '0;
      exp_pc          = '0;
      redir_prev      = 1'b0;
      acc_total       = 0;
      cons_total      = 0;
      first_valid_cyc = -1;
      rst             = 1'b0;
      release_cyc     = cyc;
      #1;
      check("release_req_valid", 32'(imem_req_valid), 32'(0));
      @(posedge clk);
   endtask

   initial begin
      logic [AW-1:0] ev[3];
      vecs[0] = '{1'b1, 1'b0, 1'b0, 19'h00100, 19'h0DEAD, 19'h00100, 19'h00101, 19'h00102};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 19'h00040, 19'h7FF00, 19'h7FF00, 19'h7FF01, 19'h7FF02};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 19'h11111, 19'h12345, 19'h12345, 19'h12346, 19'h12347};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 19'h7FFFE, 19'h00000, 19'h7FFFE, 19'h7FFFF, 19'h00000};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 19'h00200, 19'h00000, 19'h00200, 19'h00201, 19'h00202};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 19'h00000, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h00001};

      // Reset release with ready memory and single-cycle latency
      rand_ready    = 1'b0;
      rand_rsp      = 1'b0;
      lat_extra_max = 0;
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
      check("first_valid_latency", 32'(first_valid_cyc - release_cyc), 32'(FIRST_LAT));
      check("steady_throughput", 32'(got.size()), 32'(FIRST_CNT));
      if (got.size() > 0) check("first_pc", 32'(got[0]), 32'(0));
      else                check("first_pc_present", 32'(got.size()), 32'(1));

      // Stall with the queue filling: outstanding work caps at DEPTH
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
      check("stall_credit_cap", 32'(acc_total - cons_total), 32'(4));
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

      // Redirect table with multi-cycle memory latency
      lat_extra_max = 2;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
         if (vecs[i].twice) step(1'b0, 1'b1, 1'b0, 19'h55555, '0);
         step(1'b0, vecs[i].br, vecs[i].ex, vecs[i].bt, vecs[i].ha);
         got.delete();
         for (int k = 0; k < 40 && got.size() < 3; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
         check("redirect_progress", 32'(got.size() >= 3), 32'(1));
         ev[0] = vecs[i].e0;
         ev[1] = vecs[i].e1;
         ev[2] = vecs[i].e2;
         if (got.size() >= 3)
            for (int j = 0; j < 3; j++) check($sformatf("vec%0d_pc%0d", i, j), 32'(got[j]), 32'(ev[j]));
      end

      // Reset mid-operation, then randomized traffic against the model
      do_reset();
      rand_ready    = 1'b1;
      rand_rsp      = 1'b1;
      lat_extra_max = 3;
      for (int i = 0; i < 800; i++) begin
         bit            s;
         bit            b;
         bit            e;
         logic [AW-1:0] t;
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 24) == 0);
         e = ($urandom_range(0, 39) == 0);
         t = ($urandom_range(0, 3) == 0) ? AW'(19'h7FFFC + 19'($urandom_range(0, 3)))
                                          : AW'($urandom);
         step(s, b, e, t, AW'($urandom));
      end
      cons_total = 0;
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
      check("random_drain_progress", 32'(cons_total > 0), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
